// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O port controller:
// register offsets, status bit positions, data widths and the CPU request bundle.
package io_pkg;

    localparam int SW_W  = 16;
    localparam int LED_W = 12;

    localparam int LED_READY = 0;
    localparam int SW_READY  = 1;

    typedef enum logic [1:0] {
        STATUS = 2'b00,
        SWITCH = 2'b01,
        LED    = 2'b10,
        RSVD   = 2'b11
    } reg_addr_e;

    // CPU strobes already qualified by the block select
    typedef struct packed {
        logic      rd;
        logic      wr;
        reg_addr_e addr;
    } bus_req_t;

endpackage

// File: rtl/io_port_ctrl_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced
// level and a one-cycle pulse on each debounced rising edge (press).
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          level, level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            s1      <= raw;
            s2      <= s1;
            level_d <= level;
            // any sample agreeing with the accepted level restarts qualification
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: debounced buttons, switch snapshot register, LED
// register and ready flags the CPU polls; read data is combinational.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    input  logic             bntL,
    input  logic             bntR,
    input  logic [SW_W-1:0]  switch,
    output logic [SW_W-1:0]  switch_latched,
    output logic [LED_W-1:0] led
);

    logic            press_l, press_r;
    logic            sw_ready, led_ready;
    logic [SW_W-1:0] sw_s1, sw_s2;
    bus_req_t        req;
    logic            unused_wdata;

    assign req.rd   = sel & rd_en;
    assign req.wr   = sel & wr_en;
    assign req.addr = reg_addr_e'(addr);

    assign unused_wdata = ^wdata[31:LED_W];

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_l (
        .clk   (clk),
        .reset (reset),
        .raw   (bntL),
        .press (press_l)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_r (
        .clk   (clk),
        .reset (reset),
        .raw   (bntR),
        .press (press_r)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_s1          <= '0;
            sw_s2          <= '0;
            switch_latched <= '0;
            led            <= '0;
            sw_ready       <= 1'b0;
            led_ready      <= 1'b1;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;

            // a press arriving with a clearing access wins
            if (press_r) begin
                switch_latched <= sw_s2;
                sw_ready       <= 1'b1;
            end else if (req.rd && req.addr == SWITCH) begin
                sw_ready <= 1'b0;
            end

            if (press_l)
                led_ready <= 1'b1;
            else if (req.wr && req.addr == LED)
                led_ready <= 1'b0;

            if (req.wr && req.addr == LED)
                led <= wdata[LED_W-1:0];
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (req.addr)
                STATUS: begin
                    rdata[SW_READY]  = sw_ready;
                    rdata[LED_READY] = led_ready;
                end
                SWITCH:  rdata[SW_W-1:0]  = switch_latched;
                LED:     rdata[LED_W-1:0] = led;
                default: rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_port_ctrl.sv
// Scoreboarded bench for io_port_ctrl with a window-based reference model of the
// button path; the driver queues expected read responses, a monitor checks them.
module tb_io_port_ctrl;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel, rd_en, wr_en;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bntL, bntR;
    logic [15:0] switch;
    logic [15:0] switch_latched;
    logic [11:0] led;

    io_port_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk            (clk),
        .reset          (reset),
        .sel            (sel),
        .rd_en          (rd_en),
        .wr_en          (wr_en),
        .addr           (addr),
        .wdata          (wdata),
        .rdata          (rdata),
        .bntL           (bntL),
        .bntR           (bntR),
        .switch         (switch),
        .switch_latched (switch_latched),
        .led            (led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_id   = 0;

    typedef struct {
        int          id;
        logic [1:0]  a;
        logic [31:0] rd;
        logic [11:0] led;
        logic [15:0] swl;
    } exp_t;

    exp_t sbq[$];

    // Reference model state (value after the most recent rising edge)
    logic          m_swr = 1'b0, m_ledr = 1'b1;
    logic [15:0]   m_swl = '0, ms1 = '0, ms2 = '0;
    logic [11:0]   m_led = '0;
    logic [DC+1:0] hl = '0, hr = '0;   // raw samples, bit k = sample k edges ago
    logic          lvl_l = 1'b0, lvl_r = 1'b0, pend_l = 1'b0, pend_r = 1'b0;

    // A level is accepted once the synchronized input (raw two edges ago)
    // has disagreed with it for DC consecutive edges.
    task automatic model_step();
        if (!reset) begin
            m_swr = 1'b0; m_ledr = 1'b1; m_swl = '0; m_led = '0;
            ms1 = '0; ms2 = '0; hl = '0; hr = '0;
            lvl_l = 1'b0; lvl_r = 1'b0; pend_l = 1'b0; pend_r = 1'b0;
        end else begin
            if (sel && rd_en && addr == 2'b01) m_swr = 1'b0;
            if (sel && wr_en && addr == 2'b10) begin
                m_led  = wdata[11:0];
                m_ledr = 1'b0;
            end
            if (pend_r) begin m_swr = 1'b1; m_swl = ms2; end
            if (pend_l) m_ledr = 1'b1;
            ms2 = ms1;
            ms1 = switch;
            hr = {hr[DC:0], bntR};
            hl = {hl[DC:0], bntL};
            pend_r = 1'b0;
            if (lvl_r ? (hr[DC+1:2] == '0) : (&hr[DC+1:2])) begin
                lvl_r  = ~lvl_r;
                pend_r = lvl_r;
            end
            pend_l = 1'b0;
            if (lvl_l ? (hl[DC+1:2] == '0) : (&hl[DC+1:2])) begin
                lvl_l  = ~lvl_l;
                pend_l = lvl_l;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    function automatic logic [31:0] model_rdata(input logic s, input logic [1:0] a);
        logic [31:0] v;
        v = 32'h0;
        if (s) begin
            case (a)
                2'b00:   v = {30'h0, m_swr, m_ledr};
                2'b01:   v = {16'h0, m_swl};
                2'b10:   v = {20'h0, m_led};
                default: v = 32'h0;
            endcase
        end
        return v;
    endfunction

    task automatic cyc(input logic s, input logic r, input logic w,
                       input logic [1:0] a, input logic [31:0] d);
        exp_t e;
        @(posedge clk);
        #1;
        sel = s; rd_en = r; wr_en = w; addr = a; wdata = d;
        if (r) begin
            e.id  = rd_id;
            e.a   = a;
            e.rd  = model_rdata(s, a);
            e.led = m_led;
            e.swl = m_swl;
            sbq.push_back(e);
            rd_id++;
        end
    endtask

    task automatic idle();             cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0); endtask
    task automatic rd(input logic [1:0] a); cyc(1'b1, 1'b1, 1'b0, a, 32'h0); endtask
    task automatic wr(input logic [1:0] a, input logic [31:0] d); cyc(1'b1, 1'b0, 1'b1, a, d); endtask

    // Monitor: every strobed read is a DUT response to score
    always @(negedge clk) begin
        exp_t e;
        if (reset && rd_en) begin
            if (sbq.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rd_unexpected: read with no queued expectation, rdata=%h", rdata);
            end else begin
                e = sbq.pop_front();
                n_tests++;
                if (rdata !== e.rd) begin
                    n_fail++;
                    $display("FAIL rdata rd#%0d addr=%0d: got %h expected %h", e.id, e.a, rdata, e.rd);
                end
                n_tests++;
                if (led !== e.led) begin
                    n_fail++;
                    $display("FAIL led rd#%0d: got %h expected %h", e.id, led, e.led);
                end
                n_tests++;
                if (switch_latched !== e.swl) begin
                    n_fail++;
                    $display("FAIL switch_latched rd#%0d: got %h expected %h", e.id, switch_latched, e.swl);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; sel = 1'b0; rd_en = 1'b0; wr_en = 1'b0; addr = 2'b00;
        wdata = 32'h0; bntL = 1'b0; bntR = 1'b0; switch = 16'h0;
        repeat (3) idle();
        reset = 1'b1;

        // reset state
        rd(2'b00); rd(2'b01); rd(2'b10); rd(2'b11);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);

        // clean bntR press: poll STATUS every cycle to pin the latency
        switch = 16'hA5C3; bntR = 1'b1;
        repeat (9) rd(2'b00);
        rd(2'b01); rd(2'b00); rd(2'b00);
        bntR = 1'b0;
        repeat (8) rd(2'b00);

        // bounce shorter than the qualification window
        for (int i = 0; i < 5; i++) begin
            bntR = 1'b1; rd(2'b00); rd(2'b00);
            bntR = 1'b0; rd(2'b00); rd(2'b00);
        end
        switch = 16'h1111;
        repeat (6) rd(2'b00);
        rd(2'b01);

        // LED write clears led_ready, bntL press sets it again
        wr(2'b10, 32'hFFFF_FFFF);
        rd(2'b10); rd(2'b00);
        bntL = 1'b1;
        repeat (9) rd(2'b00);
        bntL = 1'b0;
        repeat (7) idle();
        rd(2'b10); rd(2'b00);

        // press pulse coinciding with a SWITCH read, then a long hold
        switch = 16'h1234; bntR = 1'b1;
        repeat (5) rd(2'b00);
        rd(2'b01);
        rd(2'b00); rd(2'b01); rd(2'b00);
        for (int i = 0; i < 50; i++) begin
            switch = 16'($urandom);
            rd((i % 5 == 0) ? 2'b01 : 2'b00);
        end
        bntR = 1'b0;
        repeat (8) rd(2'b00);

        // reset in the middle of a qualifying press, button kept held
        switch = 16'hBEEF; bntR = 1'b1;
        repeat (3) idle();
        reset = 1'b0;
        repeat (2) idle();
        reset = 1'b1;
        repeat (10) rd(2'b00);
        rd(2'b01);
        bntR = 1'b0;
        repeat (8) idle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int op;
            if ($urandom_range(19) == 0) bntL = ~bntL;
            if ($urandom_range(19) == 0) bntR = ~bntR;
            if ($urandom_range(29) == 0) switch = 16'($urandom);
            op = $urandom_range(9);
            if (op < 5)
                cyc(($urandom_range(7) != 0), 1'b1, 1'b0, 2'($urandom), 32'h0);
            else if (op < 7)
                cyc(($urandom_range(3) != 0), 1'b0, 1'b1, 2'($urandom), $urandom);
            else
                idle();
        end
        bntL = 1'b0; bntR = 1'b0;
        repeat (10) idle();
        rd(2'b00); rd(2'b01); rd(2'b10);
        idle();
        idle();

        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d expectations left, required 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
